// File: rtl/spi_bus_regs_pkg.sv
// Shared definitions for the SPI bus register slice.
// Holds the data/address widths, the register map, the CTRL/STATUS bit
// positions, the FSM state type and a helper that packs the STATUS word.
package spi_bus_regs_pkg;

  localparam int WIDTH = 8;
  localparam int MSB   = WIDTH - 1;
  localparam int ASB   = WIDTH - 2;

  // Register map (7-bit address space)
  localparam logic [ASB:0] ADDR_CTRL    = 7'h00;
  localparam logic [ASB:0] ADDR_STATUS  = 7'h01;
  localparam logic [ASB:0] ADDR_STREAM  = 7'h02;
  localparam logic [ASB:0] ADDR_SCRATCH = 7'h03;

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_FLUSH = 1;

  // Sticky flag vector layout: {overflow, underrun, stream timeout}
  localparam int STK_OVF = 2;
  localparam int STK_UNR = 1;
  localparam int STK_TMO = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // STATUS = {ovf, unr, tmo, 3'b000, level}
  function automatic logic [MSB:0] status_word(input logic [2:0] sticky,
                                               input logic [1:0] level);
    return {sticky, 3'b000, level};
  endfunction

endpackage

// File: rtl/spi_bus_regs_prefetch2.sv
// Two-entry prefetch FIFO feeding the STREAM register.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i         write din_i at the tail (caller guarantees room)
//   pop_i          drop the head entry (caller guarantees level>0)
//   flush_i        empty the FIFO; wins over push and pop
//   din_i          entry to push
//   head_o         oldest entry
//   level_o        number of valid entries, 0..2
module spi_bus_regs_prefetch2
  import spi_bus_regs_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [MSB:0] din_i,
  output logic [MSB:0] head_o,
  output logic [1:0]   level_o
);

  logic [MSB:0] mem0_q, mem0_d;  // head slot
  logic [MSB:0] mem1_q, mem1_d;  // second slot
  logic [1:0]   level_q, level_d;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    level_d = level_q;
    if (flush_i) begin
      level_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (level_q == 2'd0) begin
            mem0_d  = din_i;
            level_d = 2'd1;
          end else if (level_q == 2'd1) begin
            mem1_d  = din_i;
            level_d = 2'd2;
          end
        end
        2'b01: begin
          if (level_q != 2'd0) begin
            mem0_d  = mem1_q;
            level_d = level_q - 2'd1;
          end
        end
        2'b11: begin
          // Simultaneous push and pop keeps the level and the order.
          if (level_q == 2'd2) begin
            mem0_d = mem1_q;
            mem1_d = din_i;
          end else if (level_q == 2'd1) begin
            mem0_d = din_i;
          end else begin
            // Nothing to pop at level 0: behaves as a plain push.
            mem0_d  = din_i;
            level_d = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      level_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      level_q <= level_d;
    end
  end

  assign head_o  = mem0_q;
  assign level_o = level_q;

endmodule

// File: rtl/spi_bus_regs.sv
// Bus slave behind the SPI bus master: CTRL/STATUS/STREAM/SCRATCH registers
// answering single-outstanding cyc/stb transfers, plus a 2-entry prefetch
// buffer that keeps STREAM reads fed.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i   bus cycle, one-cycle transfer strobe, write flag
//   adr_i, dat_i         7-bit register address, write data
//   ack_o, err_o         one-cycle completion / failure pulses
//   wat_o                STREAM read stalled waiting for data
//   dat_o                read data, valid while ack_o or err_o is high
//   s_valid_i, s_data_i  upstream stream data
//   s_ready_o            prefetch accepts s_data_i this cycle
//   ovf_i, unr_i         SPI overflow / underrun event pulses
//   ctrl_o, status_o     CTRL contents, live STATUS word
//   dbg_state_o          current FSM state
//
// Stream handshake: a word transfers on every clock edge where s_valid_i
// and s_ready_o are both high; s_ready_o does not depend on s_valid_i, and
// the upstream side holds s_data_i stable while s_valid_i is high.
module spi_bus_regs
  import spi_bus_regs_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         cyc_i,
  input  logic         stb_i,
  input  logic         we_i,
  input  logic [ASB:0] adr_i,
  input  logic [MSB:0] dat_i,
  output logic         ack_o,
  output logic         err_o,
  output logic         wat_o,
  output logic [MSB:0] dat_o,
  input  logic         s_valid_i,
  input  logic [MSB:0] s_data_i,
  output logic         s_ready_o,
  input  logic         ovf_i,
  input  logic         unr_i,
  output logic [MSB:0] ctrl_o,
  output logic [MSB:0] status_o,
  output state_e       dbg_state_o
);

  localparam int          TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          wat_q, wat_d;
  logic [MSB:0]  dat_q, dat_d;
  logic [MSB:0]  ctrl_q, ctrl_d;
  logic [MSB:0]  scratch_q, scratch_d;
  logic [2:0]    sticky_q, sticky_d;

  logic          sticky_clr;
  logic          tmo_set;
  logic          pop;
  logic          push;
  logic [MSB:0]  head;
  logic [1:0]    level;

  assign s_ready_o = ctrl_q[CTRL_EN] && (level != 2'd2) && !ctrl_q[CTRL_FLUSH];
  assign push      = s_valid_i && s_ready_o;

  spi_bus_regs_prefetch2 u_prefetch (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (ctrl_q[CTRL_FLUSH]),
    .din_i   (s_data_i),
    .head_o  (head),
    .level_o (level)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    wat_d      = 1'b0;
    dat_d      = '0;
    ctrl_d     = ctrl_q;
    // Flush is a one-cycle pulse: it only survives the cycle after its write.
    ctrl_d[CTRL_FLUSH] = 1'b0;
    scratch_d  = scratch_q;
    sticky_clr = 1'b0;
    tmo_set    = 1'b0;
    pop        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A strobe during the ack/err cycle belongs to the finished transfer.
        if (cyc_i && stb_i && !ack_q && !err_q) begin
          case (adr_i)
            ADDR_CTRL: begin
              ack_d = 1'b1;
              if (we_i) ctrl_d = dat_i;
              else      dat_d  = ctrl_q;
            end
            ADDR_STATUS: begin
              if (we_i) begin
                err_d = 1'b1;
              end else begin
                ack_d      = 1'b1;
                dat_d      = status_o;
                sticky_clr = 1'b1;
              end
            end
            ADDR_STREAM: begin
              if (we_i) begin
                err_d = 1'b1;
              end else if (level != 2'd0) begin
                ack_d = 1'b1;
                dat_d = head;
                pop   = 1'b1;
              end else begin
                state_d = ST_WAIT;
                timer_d = '0;
                wat_d   = 1'b1;
              end
            end
            ADDR_SCRATCH: begin
              ack_d = 1'b1;
              if (we_i) scratch_d = dat_i;
              else      dat_d     = scratch_q;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          // Master abandoned the transfer: no response, buffer untouched.
          state_d = ST_IDLE;
        end else if (level != 2'd0) begin
          ack_d   = 1'b1;
          dat_d   = head;
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else if (timer_q == TMAX) begin
          err_d   = 1'b1;
          tmo_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
          wat_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new event in the read-to-clear cycle keeps its bit set.
    sticky_d = (sticky_q & ~{3{sticky_clr}}) | {ovf_i, unr_i, tmo_set};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      wat_q     <= 1'b0;
      dat_q     <= '0;
      ctrl_q    <= '0;
      scratch_q <= '0;
      sticky_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      wat_q     <= wat_d;
      dat_q     <= dat_d;
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      sticky_q  <= sticky_d;
    end
  end

  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign wat_o       = wat_q;
  assign dat_o       = dat_q;
  assign ctrl_o      = ctrl_q;
  assign status_o    = status_word(sticky_q, level);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_bus_regs.sv
module tb_spi_bus_regs;
  import spi_bus_regs_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int EW      = 10;  // {data_care, is_err, data[7:0]}

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  always #5 clk = ~clk;

  logic       cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [6:0] adr_i = '0;
  logic [7:0] dat_i = '0;
  logic       ack_o, err_o, wat_o;
  logic [7:0] dat_o;
  logic       s_valid_i = 1'b0;
  logic [7:0] s_data_i = '0;
  logic       s_ready_o;
  logic       ovf_i = 1'b0, unr_i = 1'b0;
  logic [7:0] ctrl_o, status_o;
  state_e     dbg_state;

  spi_bus_regs #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .ack_o(ack_o), .err_o(err_o), .wat_o(wat_o),
    .dat_o(dat_o), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_ready_o(s_ready_o), .ovf_i(ovf_i), .unr_i(unr_i), .ctrl_o(ctrl_o),
    .status_o(status_o), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  logic [7:0] m_ctrl, m_scr;
  logic [7:0] m_fifo[$];
  logic [2:0] m_sticky;  // {ovf, unr, tmo}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    logic [1:0] lvl;
    lvl = 2'(m_fifo.size());
    return {m_sticky, 3'b000, lvl};
  endfunction

  task automatic model_reset();
    m_ctrl = 8'h00;
    m_scr  = 8'h00;
    m_fifo.delete();
    m_sticky = 3'b000;
    exp_q.delete();
  endtask

  // Expected response of one non-stalling access, updating the model.
  function automatic logic [EW-1:0] model_access(input logic we, input logic [6:0] adr,
                                                 input logic [7:0] d, input logic ovf_with);
    logic [7:0] r;
    logic       e;
    r = 8'h00;
    e = 1'b0;
    case (adr)
      7'h00: if (we) begin
               m_ctrl = d & 8'hFD;
               if (d[1]) m_fifo.delete();
             end else r = m_ctrl;
      7'h01: if (we) e = 1'b1;
             else begin
               r = m_status();
               m_sticky = 3'b000;
             end
      7'h02: if (we) e = 1'b1;
             else r = m_fifo.pop_front();
      7'h03: if (we) m_scr = d; else r = m_scr;
      default: e = 1'b1;
    endcase
    if (ovf_with) m_sticky[2] = 1'b1;
    return {(!we || e), e, r};
  endfunction

  // Monitor: every response pops one expectation.
  always @(negedge clk) begin
    if (rst_ni && (ack_o || err_o)) begin
      logic [EW-1:0] e;
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {ack_o, err_o}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        chk("resp_kind", {ack_o, err_o}, {!e[8], e[8]});
        if (e[9]) chk("resp_data", dat_o, e[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic post_check();
    @(negedge clk);
    chk("status_o", status_o, m_status());
    chk("ctrl_o", ctrl_o, m_ctrl);
    chk("idle_state", dbg_state, ST_IDLE);
  endtask

  task automatic xfer(input logic we, input logic [6:0] adr, input logic [7:0] d,
                      input logic ovf_with);
    int lat;
    @(negedge clk);
    exp_q.push_back(model_access(we, adr, d, ovf_with));
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = d; ovf_i = ovf_with;
    @(negedge clk);
    stb_i = 1'b0; ovf_i = 1'b0;
    lat = 1;
    while (!(ack_o || err_o) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 1);
    cyc_i = 1'b0;
    post_check();
  endtask

  task automatic push(input logic [7:0] d);
    logic rdy;
    @(negedge clk);
    s_valid_i = 1'b1; s_data_i = d;
    rdy = m_ctrl[0] && (m_fifo.size() < 2);
    #1 chk("s_ready", s_ready_o, rdy);
    @(negedge clk);
    s_valid_i = 1'b0;
    if (rdy) m_fifo.push_back(d);
    chk("level", status_o[1:0], m_fifo.size());
  endtask

  task automatic pulse(input logic ovf, input logic unr);
    @(negedge clk);
    ovf_i = ovf; unr_i = unr;
    @(negedge clk);
    ovf_i = 1'b0; unr_i = 1'b0;
    if (ovf) m_sticky[2] = 1'b1;
    if (unr) m_sticky[1] = 1'b1;
    chk("sticky_set", status_o, m_status());
  endtask

  // STREAM read from an empty buffer; push_after>0 feeds d at that cycle,
  // push_after==0 lets it time out.
  task automatic stream_wait(input int push_after, input logic [7:0] d);
    int n, wats;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 7'h02; s_data_i = d;
    if (push_after > 0) exp_q.push_back({2'b10, d});
    else                exp_q.push_back({2'b11, 8'h00});
    @(negedge clk);
    stb_i = 1'b0;
    n = 1; wats = 0;
    while (!(ack_o || err_o) && n < 60) begin
      if (wat_o) wats++;
      s_valid_i = (n == push_after);
      @(negedge clk);
      n++;
    end
    s_valid_i = 1'b0;
    if (push_after > 0) begin
      chk("wait_lat", n, push_after + 2);
      chk("wait_cycles", wats, push_after + 1);
    end else begin
      m_sticky[0] = 1'b1;
      chk("tmo_lat", n, TIMEOUT + 1);
      chk("tmo_cycles", wats, TIMEOUT);
    end
    chk("wat_in_resp", wat_o, 1'b0);
    cyc_i = 1'b0;
    post_check();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_wat", wat_o, 1'b0);
    chk("rst_s_ready", s_ready_o, 1'b0);
    cyc_i = 1'b0; stb_i = 1'b0; s_valid_i = 1'b0; ovf_i = 1'b0; unr_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_status", status_o, 8'h00);
    chk("rst_ctrl", ctrl_o, 8'h00);
    chk("rst_state", dbg_state, ST_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #2 rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ack", ack_o, 1'b0);
    chk("reset_err", err_o, 1'b0);
    chk("reset_wat", wat_o, 1'b0);
    chk("reset_s_ready", s_ready_o, 1'b0);
    chk("reset_dat", dat_o, 8'h00);
    chk("reset_ctrl", ctrl_o, 8'h00);
    chk("reset_status", status_o, 8'h00);
    chk("reset_state", dbg_state, ST_IDLE);
    rst_ni = 1'b1;

    // Scratch
    xfer(1'b0, 7'h03, 8'h00, 1'b0);
    xfer(1'b1, 7'h03, 8'hA5, 1'b0);
    xfer(1'b0, 7'h03, 8'h00, 1'b0);

    // Prefetch fill and drain
    xfer(1'b1, 7'h00, 8'h01, 1'b0);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    xfer(1'b0, 7'h02, 8'h00, 1'b0);
    xfer(1'b0, 7'h02, 8'h00, 1'b0);

    // Stall then data, then timeout
    stream_wait(4, 8'h5C);
    stream_wait(0, 8'h00);
    xfer(1'b0, 7'h01, 8'h00, 1'b0);
    xfer(1'b0, 7'h01, 8'h00, 1'b0);

    // Sticky set coincident with read-to-clear
    pulse(1'b1, 1'b0);
    xfer(1'b0, 7'h01, 8'h00, 1'b1);
    xfer(1'b0, 7'h01, 8'h00, 1'b0);

    // Error accesses leave registers unchanged
    xfer(1'b1, 7'h01, 8'hFF, 1'b0);
    xfer(1'b0, 7'h40, 8'h00, 1'b0);
    xfer(1'b1, 7'h02, 8'h77, 1'b0);
    xfer(1'b0, 7'h03, 8'h00, 1'b0);

    // Flush empties a full buffer
    push(8'h44);
    push(8'h55);
    xfer(1'b1, 7'h00, 8'h03, 1'b0);
    push(8'h66);

    // cyc_i dropped mid-wait: no response, nothing popped
    xfer(1'b0, 7'h02, 8'h00, 1'b0);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 7'h02;
    @(negedge clk);
    stb_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_wat_hi", wat_o, 1'b1);
    cyc_i = 1'b0;
    @(negedge clk);
    chk("abort_wat_lo", wat_o, 1'b0);
    chk("abort_state", dbg_state, ST_IDLE);
    repeat (3) @(negedge clk);
    push(8'h9A);
    xfer(1'b0, 7'h02, 8'h00, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      case ($urandom_range(0, 8))
        0: xfer(1'b1, 7'h03, d, 1'b0);
        1: xfer(1'b0, 7'h03, 8'h00, 1'b0);
        2: begin
             d[0] = ($urandom_range(0, 3) != 0);
             d[1] = ($urandom_range(0, 7) == 0);
             xfer(1'b1, 7'h00, d, 1'b0);
           end
        3: xfer(1'b0, 7'h00, 8'h00, 1'b0);
        4: xfer(1'b0, 7'h01, 8'h00, ($urandom_range(0, 3) == 0));
        5: push(d);
        6: if (m_fifo.size() > 0) xfer(1'b0, 7'h02, 8'h00, 1'b0);
           else push(d);
        7: pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: begin
          if ($urandom_range(0, 1) == 1)
            xfer(1'($urandom_range(0, 1)), 7'($urandom_range(4, 127)), d, 1'b0);
          else
            xfer(1'b1, 7'($urandom_range(1, 2)), d, 1'b0);
        end
      endcase
    end

    // Reset during WAIT
    xfer(1'b1, 7'h00, 8'h03, 1'b0);
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 7'h02;
    @(negedge clk);
    stb_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_wat", wat_o, 1'b1);
    do_reset();

    // Reset with a full buffer
    xfer(1'b1, 7'h00, 8'h01, 1'b0);
    push(8'hC1);
    push(8'hC2);
    do_reset();
    xfer(1'b0, 7'h03, 8'h00, 1'b0);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
